// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Cycles beyond WIDTH between start and done: the counter's terminal cycle plus FIX.
  localparam int DIV_EXTRA_CYCLES = 2;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in the next dividend bit,
// subtract the divisor when it fits and emit the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // A set top bit means the shifted value exceeds WIDTH+1 bits and is always
  // larger than the divisor; the wrapped difference is still exact.
  assign shifted = {rem_in[WIDTH-1:0], dividend_bit};
  assign q_bit   = rem_in[WIDTH] | (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? (shifted - {1'b0, divisor}) : shifted;

endmodule

// File: rtl/seq_div.sv
// Multi-cycle signed/unsigned restoring divider; Z = {remainder, quotient}.
// Optional macro SEQ_DIV_DBZ_EN adds a dbz flag and a short path for B=0.
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Z
`ifdef SEQ_DIV_DBZ_EN
  ,
  output logic               dbz
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state_reg, state_next, start_target;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic             neg_q_reg, neg_r_reg, dz_reg;

  logic             accept, b_zero, a_neg, b_neg, calc_iter;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  assign accept    = start & ((state_reg == IDLE) | (state_reg == DONE));
  assign b_zero    = (B == '0);
  assign a_neg     = is_signed & A[WIDTH-1];
  assign b_neg     = is_signed & B[WIDTH-1];
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;
  assign calc_iter = (state_reg == CALC) && (cnt_reg != CW'(WIDTH));

`ifdef SEQ_DIV_DBZ_EN
  assign start_target = b_zero ? DONE : CALC;
`else
  assign start_target = CALC;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = start_target;
      CALC: begin
        busy = 1'b1;
        if (cnt_reg == CW'(WIDTH)) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? start_target : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem_reg),
    .dividend_bit (quo_reg[WIDTH-1]),
    .divisor      (dvs_reg),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  // Quotient negates on differing signs; remainder follows the dividend.
  assign q_fix = neg_q_reg ? -quo_reg : quo_reg;
  assign r_fix = neg_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];

  // The dividend shifts out of quo_reg as quotient bits shift in.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      dz_reg    <= 1'b0;
      Z         <= '0;
`ifdef SEQ_DIV_DBZ_EN
      dbz       <= 1'b0;
`endif
    end else if (accept) begin
      cnt_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= a_mag;
      dvs_reg   <= b_mag;
      neg_q_reg <= a_neg ^ b_neg;
      neg_r_reg <= a_neg;
      dz_reg    <= b_zero;
`ifdef SEQ_DIV_DBZ_EN
      dbz       <= b_zero;
      if (b_zero) Z <= '0;
`endif
    end else if (calc_iter) begin
      rem_reg <= step_rem;
      quo_reg <= {quo_reg[WIDTH-2:0], step_q};
      cnt_reg <= cnt_reg + CW'(1);
    end else if (state_reg == FIX) begin
      Z <= dz_reg ? '0 : {r_fix, q_fix};
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div at WIDTH=32 (handles SEQ_DIV_DBZ_EN).
module tb_seq_div;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done;
  logic [63:0] Z;
`ifdef SEQ_DIV_DBZ_EN
  logic        dbz;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  seq_div #(.WIDTH(32)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .is_signed (is_signed),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .Z         (Z)
`ifdef SEQ_DIV_DBZ_EN
    ,
    .dbz       (dbz)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Drive start for exactly one rising edge from the current (non-edge) time.
  task automatic launch_now(input logic [31:0] a, input logic [31:0] b, input logic s);
    A = a; B = b; is_signed = s; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clock);
    launch_now(a, b, s);
  endtask

  // Count edges after the start edge until done is seen; bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      lat++;
      if (done) break;
    end
    if (!done) check_eq("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic run_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp_z, input int exp_lat);
    int lat;
    launch(a, b, s);
    wait_done(lat);
    check_eq({tag, "_z"}, Z, exp_z);
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    int lat, lat2, seen;

    #2;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_z", Z, 64'd0);
    @(negedge clock); clear = 1'b0;

    run_case("s_basic",  32'd100,        32'd7,          1'b1, 64'h00000002_0000000E, 34);
    run_case("s_neg",    -32'sd100,      32'd7,          1'b1, 64'hFFFFFFFE_FFFFFFF2, 34);
    run_case("s_negdiv", 32'd100,        -32'sd7,        1'b1, 64'h00000002_FFFFFFF2, 34);
    run_case("u_max",    32'hFFFFFFFF,   32'd2,          1'b0, 64'h00000001_7FFFFFFF, 34);
    run_case("u_small",  32'd7,          32'd100,        1'b0, 64'h00000007_00000000, 34);
    run_case("s_ovf",    32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000, 34);
`ifdef SEQ_DIV_DBZ_EN
    run_case("dbz",      32'd5,          32'd0,          1'b1, 64'd0, 1);
    check_eq("dbz_flag", 64'(dbz), 64'd1);
`else
    run_case("dbz",      32'd5,          32'd0,          1'b1, 64'd0, 34);
`endif

    // Start pulse during CALC must be ignored.
    launch(32'd100, 32'd7, 1'b1);
`ifdef SEQ_DIV_DBZ_EN
    check_eq("dbz_cleared", 64'(dbz), 64'd0);
`endif
    lat = 0;
    repeat (9) begin @(posedge clock); #1; lat++; end
    A = 32'd1; B = 32'd1; is_signed = 1'b0; start = 1'b1;
    @(posedge clock); #1; lat++;
    start = 1'b0;
    check_eq("ign_busy", 64'(busy), 64'd1);
    wait_done(lat2);
    check_eq("ign_lat", 64'(lat + lat2), 64'd34);
    check_eq("ign_z", Z, 64'h00000002_0000000E);

    // Back-to-back start in the DONE cycle.
    launch_now(-32'sd100, 32'd7, 1'b1);
    check_eq("b2b_busy", 64'(busy), 64'd1);
    check_eq("b2b_zhold", Z, 64'h00000002_0000000E);
    wait_done(lat);
    check_eq("b2b_lat", 64'(lat), 64'd34);
    check_eq("b2b_z", Z, 64'hFFFFFFFE_FFFFFFF2);

    // Asynchronous clear mid-operation.
    launch(32'hFFFFFFFF, 32'd2, 1'b0);
    repeat (15) @(posedge clock);
    #3;
    clear = 1'b1;
    #1;
    check_eq("clr_busy", 64'(busy), 64'd0);
    check_eq("clr_done", 64'(done), 64'd0);
    check_eq("clr_z", Z, 64'd0);
    @(negedge clock); clear = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clock); #1; if (done || busy) seen++; end
    check_eq("clr_quiet", 64'(seen), 64'd0);
    run_case("post_clr", 32'd100, 32'd7, 1'b1, 64'h00000002_0000000E, 34);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; legal values are 8 to 64.
REQ-002 clock  input  1  Single clock; all state changes on the rising edge.
REQ-003 clear  input  1  Reset, asynchronous and active-high.
REQ-004 start  input  1  Request a division; sampled only in IDLE or DONE.
REQ-005 is_signed  input  1  1 selects signed (DIV), 0 selects unsigned (DIVU); sampled with start.
REQ-006 A  input  WIDTH  Dividend; sampled with start.
REQ-007 B  input  WIDTH  Divisor; sampled with start.
REQ-008 busy  output  1  High while a division is in progress (CALC and FIX states).
REQ-009 done  output  1  One-cycle pulse marking Z valid.
REQ-010 Z  output  2*WIDTH  Result: remainder in Z[2W-1:W] (HI) and quotient in Z[W-1:0] (LO).

Function
REQ-011 The FSM SHALL have states IDLE, CALC, FIX and DONE.
- IDLE -> CALC on start.
- CALC -> FIX after exactly WIDTH iterations.
- FIX -> DONE.
- DONE -> CALC on start, otherwise DONE -> IDLE.
REQ-012 On an accepted start, the divider SHALL latch operand magnitudes (absolute values when is_signed=1), the result signs and the mode.
REQ-013 CALC SHALL perform one restoring shift-subtract iteration per cycle, MSB first, using a (WIDTH+1)-bit partial remainder.
REQ-014 FIX SHALL apply sign correction:
- the quotient is negated when the operand signs differ;
- the remainder takes the sign of the dividend (truncation toward zero).
REQ-015 Latency: start sampled at edge k SHALL give done=1 in the cycle after edge k+WIDTH+2, with Z valid in that same cycle.
REQ-016 Z SHALL hold its value from DONE until the FIX state of the next operation.
REQ-017 Z SHALL NOT change while busy=1.
REQ-018 start SHALL be ignored while busy=1; no queueing, and no change to the operation in flight.
REQ-019 Divide by zero (B=0) SHALL produce Z=0, matching the existing single-cycle DIV semantics.
REQ-020 Signed overflow (A = most-negative value, B = -1) SHALL produce quotient = most-negative value and remainder = 0.
REQ-021 When is_signed=0, operands SHALL be treated as unsigned with no sign correction.

Reset
REQ-022 Asserting clear SHALL asynchronously force: state=IDLE, busy=0, done=0, Z=0, iteration counter=0.
REQ-023 clear asserted mid-operation SHALL abort the operation; no done pulse is issued for the aborted operation.
REQ-024 After clear is released, the first start SHALL be accepted normally.

Configuration
REQ-025 Macro SEQ_DIV_DBZ_EN defined: an extra output dbz (1 bit) is added.
- On start with B=0, the FSM SHALL go IDLE/DONE -> DONE directly (done one cycle after the start edge).
- dbz=1 and Z=0 for that operation.
- dbz SHALL be cleared by the next accepted start or by clear.
REQ-026 Macro SEQ_DIV_DBZ_EN undefined: no dbz port; B=0 SHALL take the full WIDTH+2 latency and give Z=0.

Structure
REQ-027 The shared package div_pkg SHALL hold:
- the state enum type div_state_t (IDLE, CALC, FIX, DONE);
- the constant DIV_EXTRA_CYCLES=2.
REQ-028 One iteration SHALL be a combinational sub-module div_step, parameterised by WIDTH.
- Inputs: partial remainder, next dividend bit, divisor.
- Outputs: new partial remainder, quotient bit.
REQ-029 The iteration counter SHALL be $clog2(WIDTH+1) bits wide.
REQ-030 No combinational path SHALL exist from inputs to outputs.

Verification (WIDTH=32)
REQ-031 Signed basic: A=100, B=7, is_signed=1 -> Z=64'h00000002_0000000E, done exactly 34 cycles after start.
REQ-032 Signed negative: A=-100, B=7, is_signed=1 -> Z=64'hFFFFFFFE_FFFFFFF2.
REQ-033 Unsigned and overflow:
- A=32'hFFFFFFFF, B=2, is_signed=0 -> Z=64'h00000001_7FFFFFFF.
- A=32'h80000000, B=32'hFFFFFFFF, is_signed=1 -> Z=64'h00000000_80000000.
REQ-034 Divide by zero: A=5, B=0 -> Z=0.
- With SEQ_DIV_DBZ_EN: done 1 cycle after start, dbz=1.
- Without SEQ_DIV_DBZ_EN: done after 34 cycles.
REQ-035 Handshake: start pulsed again in cycle 10 of a busy operation -> ignored, first result unchanged; back-to-back start in the DONE cycle -> accepted, second done 34 cycles later.
REQ-036 Reset: clear asserted at CALC iteration 15 -> busy=0, done=0 and Z=0 immediately, no done pulse afterward; next start completes correctly.
